mem_arbiter: RTL and testbench

- Arbitrates the single shared 4-cycle pipelined main memory between three requesters:
  - I-cache fill (block read)
  - D-cache fill (block read)
  - D-cache write-through (single-word write)
- On grant of a fill, it sequences the block's 8 word addresses and counts returning data.
- It routes memory data to the owning cache with a word index, and pulses that cache's done signal on the last word.
- Sits between both cache fill controllers and the memory model; its busy/grant outputs feed the pipeline stall logic.

---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-way arbiter for the shared pipelined main memory: I-fill, D-fill and D write-through.
// Optional ARB_ROUND_ROBIN_EN alternates D/I fill grants when both caches miss together.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic              d_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
);

  localparam int BLK_W = ADDR_W - IDX_W - 1;
  localparam logic [IDX_W:0]   ISSUE_END = (IDX_W + 1)'(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, WRITE} state_t;

  state_t           state;
  logic [IDX_W:0]   issue_cnt;
  logic [IDX_W-1:0] ret_cnt;
  logic [BLK_W-1:0] blk;
  logic             in_fill;
  logic             last_word;
  logic             pick_d;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[IDX_W:0], d_addr[IDX_W:0]};

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = I-cache was the last fill owner, 1 = D-cache
  logic last_fill_owner;
  assign pick_d = d_req && (!i_req || !last_fill_owner);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fill_owner <= 1'b0;
    end else if (state == IDLE && !wr_req) begin
      if (pick_d) begin
        last_fill_owner <= 1'b1;
      end else if (i_req) begin
        last_fill_owner <= 1'b0;
      end
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign in_fill   = (state == I_FILL) || (state == D_FILL);
  assign last_word = in_fill && mem_valid && (ret_cnt == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      blk       <= '0;
    end else begin
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          ret_cnt   <= '0;
          if (wr_req) begin
            state <= WRITE;
            blk   <= wr_addr[ADDR_W-1:IDX_W+1];
          end else if (pick_d) begin
            state <= D_FILL;
            blk   <= d_addr[ADDR_W-1:IDX_W+1];
          end else if (i_req) begin
            state <= I_FILL;
            blk   <= i_addr[ADDR_W-1:IDX_W+1];
          end
        end
        WRITE: state <= IDLE;
        I_FILL, D_FILL: begin
          if (issue_cnt != ISSUE_END) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          // Completion is driven purely by counted returns, not by a latency constant
          if (mem_valid) begin
            if (ret_cnt == LAST_IDX) begin
              state     <= IDLE;
              issue_cnt <= '0;
              ret_cnt   <= '0;
            end else begin
              ret_cnt <= ret_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_grant      = (state == I_FILL);
  assign d_grant      = (state == D_FILL);
  assign busy         = (state != IDLE);
  assign i_data_valid = i_grant && mem_valid;
  assign d_data_valid = d_grant && mem_valid;
  assign i_done       = i_grant && last_word;
  assign d_done       = d_grant && last_word;
  assign fill_data    = mem_rdata;
  assign fill_idx     = ret_cnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (state == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
      wr_ack    = 1'b1;
    end else if (in_fill && issue_cnt != ISSUE_END) begin
      mem_en   = 1'b1;
      mem_addr = {blk, issue_cnt[IDX_W-1:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined read memory model.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        i_req, d_req, wr_req;
  logic [15:0] i_addr, d_addr, wr_addr, wr_data;
  logic        i_grant, i_data_valid, i_done;
  logic        d_grant, d_data_valid, d_done;
  logic        wr_ack, busy, mem_en, mem_wr, mem_valid;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_idx;
  logic        force_valid;
  int          checks = 0;
  int          errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
    .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant),
    .d_data_valid(d_data_valid), .d_done(d_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_data(fill_data), .fill_idx(fill_idx), .busy(busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read issued in cycle k returns in cycle k+4, data = addr ^ A5A5
  logic [3:0]  pv;
  logic [15:0] pa0, pa1, pa2, pa3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= 4'b0; pa0 <= 16'h0; pa1 <= 16'h0; pa2 <= 16'h0; pa3 <= 16'h0;
    end else begin
      pv  <= {pv[2:0], mem_en & ~mem_wr};
      pa0 <= mem_addr; pa1 <= pa0; pa2 <= pa1; pa3 <= pa2;
    end
  end
  assign mem_valid = pv[3] | force_valid;
  assign mem_rdata = pv[3] ? (pa3 ^ 16'hA5A5) : 16'h0;

  task automatic test_reset;
    rst = 1'b1;
    i_req = 0; d_req = 0; wr_req = 0; force_valid = 0;
    i_addr = 0; d_addr = 0; wr_addr = 0; wr_data = 0;
    #3;
    checks++;
    if ({i_grant, d_grant, i_data_valid, i_done, d_data_valid, d_done, wr_ack, mem_en, mem_wr, busy} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {i_grant, d_grant, i_data_valid, i_done, d_data_valid, d_done, wr_ack, mem_en, mem_wr, busy});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem got addr %h wdata %h exp 0", mem_addr, mem_wdata);
    end
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_i_fill;
    logic [15:0] exp_addr;
    logic        exp_en, exp_val;
    i_req = 1'b1; i_addr = 16'h1234;
    #1;
    checks++;
    if (i_grant !== 1'b0) begin
      errors++; $display("FAIL i_fill c0 i_grant got %b exp 0", i_grant);
    end
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      exp_en   = (c <= 8);
      exp_addr = exp_en ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0;
      exp_val  = (c >= 5 && c <= 12);
      checks++;
      if (i_grant !== 1'(c <= 12) || busy !== 1'(c <= 12)) begin
        errors++; $display("FAIL i_fill c%0d grant/busy got %b%b exp %b", c, i_grant, busy, 1'(c <= 12));
      end
      checks++;
      if (mem_en !== exp_en || mem_wr !== 1'b0 || mem_addr !== exp_addr) begin
        errors++; $display("FAIL i_fill c%0d mem got en %b wr %b addr %h exp en %b addr %h", c, mem_en, mem_wr, mem_addr, exp_en, exp_addr);
      end
      checks++;
      if (i_data_valid !== exp_val || d_data_valid !== 1'b0 || i_done !== 1'(c == 12)) begin
        errors++; $display("FAIL i_fill c%0d valid/dvalid/done got %b%b%b exp %b0%b", c, i_data_valid, d_data_valid, i_done, exp_val, 1'(c == 12));
      end
      if (exp_val) begin
        checks++;
        if (fill_idx !== 3'(c - 5) || fill_data !== ((16'h1230 + 16'(2 * (c - 5))) ^ 16'hA5A5)) begin
          errors++; $display("FAIL i_fill c%0d idx/data got %0d %h exp %0d %h", c, fill_idx, fill_data, c - 5, (16'h1230 + 16'(2 * (c - 5))) ^ 16'hA5A5);
        end
      end
      if (c == 12) i_req = 1'b0;
    end
    $display("i_fill: block 0x1230 complete");
  endtask

  task automatic test_arbitration;
    logic        d_ph, i_ph;
    int          k;
    logic [15:0] exp_addr;
    d_req = 1'b1; d_addr = 16'hA00C;
    i_req = 1'b1; i_addr = 16'h1234;
    #1;
    checks++;
    if (d_grant !== 1'b0 || i_grant !== 1'b0) begin
      errors++; $display("FAIL arb c0 grants got %b%b exp 00", d_grant, i_grant);
    end
    for (int c = 1; c <= 26; c++) begin
      @(posedge clk); #1;
      d_ph = (c >= 1 && c <= 12);
      i_ph = (c >= 14 && c <= 25);
      k    = d_ph ? c : c - 13;
      exp_addr = 16'h0;
      if (d_ph && k <= 8) exp_addr = 16'hA000 + 16'(2 * (k - 1));
      if (i_ph && k <= 8) exp_addr = 16'h1230 + 16'(2 * (k - 1));
      checks++;
      if (d_grant !== d_ph || i_grant !== i_ph || busy !== (d_ph | i_ph)) begin
        errors++; $display("FAIL arb c%0d d/i/busy got %b%b%b exp %b%b%b", c, d_grant, i_grant, busy, d_ph, i_ph, d_ph | i_ph);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++; $display("FAIL arb c%0d mem_addr got %h exp %h", c, mem_addr, exp_addr);
      end
      checks++;
      if (d_data_valid !== (d_ph && k >= 5) || i_data_valid !== (i_ph && k >= 5)) begin
        errors++; $display("FAIL arb c%0d dvalid/ivalid got %b%b exp %b%b", c, d_data_valid, i_data_valid, d_ph && k >= 5, i_ph && k >= 5);
      end
      checks++;
      if (d_done !== (d_ph && k == 12) || i_done !== (i_ph && k == 12)) begin
        errors++; $display("FAIL arb c%0d d_done/i_done got %b%b", c, d_done, i_done);
      end
      if ((d_ph || i_ph) && k >= 5) begin
        checks++;
        if (fill_idx !== 3'(k - 5)) begin
          errors++; $display("FAIL arb c%0d fill_idx got %0d exp %0d", c, fill_idx, k - 5);
        end
      end
      if (c == 12) d_req = 1'b0;
      if (c == 25) i_req = 1'b0;
    end
    $display("arbitration: D fill then I fill");
  endtask

  task automatic test_write;
    wr_req = 1'b1; wr_addr = 16'h0040; wr_data = 16'hBEEF;
    d_req = 1'b1; d_addr = 16'hA00C;
    i_req = 1'b1; i_addr = 16'h1234;
    #1;
    checks++;
    if (wr_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL write c0 ack/en got %b%b exp 00", wr_ack, mem_en);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF || wr_ack !== 1'b1) begin
      errors++; $display("FAIL write c1 got en %b wr %b addr %h wdata %h ack %b exp 1 1 0040 beef 1", mem_en, mem_wr, mem_addr, mem_wdata, wr_ack);
    end
    checks++;
    if (d_grant !== 1'b0 || i_grant !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL write c1 grants/busy got %b%b%b exp 001", d_grant, i_grant, busy);
    end
    wr_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || wr_ack !== 1'b0 || mem_wr !== 1'b0 || mem_wdata !== 16'h0 || d_grant !== 1'b0) begin
      errors++; $display("FAIL write c2 idle got busy %b ack %b wr %b wdata %h dg %b", busy, wr_ack, mem_wr, mem_wdata, d_grant);
    end
    for (int c = 3; c <= 28; c++) begin
      @(posedge clk); #1;
      checks++;
      if (d_grant !== 1'(c <= 14) || i_grant !== 1'(c >= 16 && c <= 27)) begin
        errors++; $display("FAIL write_then_fill c%0d d/i grant got %b%b", c, d_grant, i_grant);
      end
      checks++;
      if (d_done !== 1'(c == 14) || i_done !== 1'(c == 27)) begin
        errors++; $display("FAIL write_then_fill c%0d d/i done got %b%b", c, d_done, i_done);
      end
      if (c == 3 || c == 16) begin
        checks++;
        if (mem_addr !== ((c == 3) ? 16'hA000 : 16'h1230) || mem_wr !== 1'b0) begin
          errors++; $display("FAIL write_then_fill c%0d first addr got %h wr %b", c, mem_addr, mem_wr);
        end
      end
      if (c == 14) d_req = 1'b0;
      if (c == 27) i_req = 1'b0;
    end
    $display("write: write, D fill, I fill");
  endtask

  task automatic test_reset_mid_fill;
    d_req = 1'b1; d_addr = 16'hA00C;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (d_grant !== 1'b1) begin
      errors++; $display("FAIL rst_mid c6 d_grant got %b exp 1", d_grant);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d_grant !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0 || d_data_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid async got dg %b en %b busy %b dv %b exp 0000", d_grant, mem_en, busy, d_data_valid);
    end
    d_req = 1'b0;
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    $display("reset_mid_fill: abandoned D fill");
    test_i_fill();
  endtask

  task automatic test_idle_valid;
    force_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({i_data_valid, d_data_valid, i_done, d_done, busy} !== 5'b0) begin
        errors++; $display("FAIL idle_valid c%0d got %b exp 00000", c, {i_data_valid, d_data_valid, i_done, d_done, busy});
      end
    end
    force_valid = 1'b0;
    @(posedge clk); #1;
    $display("idle_valid: stray mem_valid ignored");
  endtask

  initial begin
    test_reset();
    test_i_fill();
    for (int r = 0; r < 2; r++) test_arbitration();
    test_write();
    test_reset_mid_fill();
    test_idle_valid();
    test_i_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
